// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants and GF(2^8) helpers for the encrypt and decrypt datapaths.
package aes_pkg;

   typedef enum logic {IDLE, ROUNDS} state_e;

   localparam logic [7:0] RCON [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16};

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[b];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

endpackage

// File: rtl/aes_key_step.sv
// aes_key_step: one AES-128 key-schedule step, previous round key to next round key.
module aes_key_step
   import aes_pkg::*;
(
   input  logic [127:0] rk_prev,
   input  logic [7:0]   rcon,
   output logic [127:0] rk_next
);

   logic [31:0] w0, w1, w2, w3, t, w4, w5, w6, w7;

   always_comb begin
      {w0, w1, w2, w3} = rk_prev;
      t = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rcon, 24'h0};
      w4 = w0 ^ t;
      w5 = w1 ^ w4;
      w6 = w2 ^ w5;
      w7 = w3 ^ w6;
      rk_next = {w4, w5, w6, w7};
   end

endmodule

// File: rtl/aes128_encrypt_core.sv
// aes128_encrypt_core: iterative AES-128 encryption, one round per clock with
// the round key expanded on the fly alongside the state.
module aes128_encrypt_core
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         n_rst,
   input  logic         encryptEnable,
   input  logic [127:0] key,
   input  logic [127:0] inputData,
   output logic [127:0] outputData,
   output logic         dataReady,
   output logic         busy
);

   state_e       state_q, state_d;
   logic [3:0]   round_q, round_d;
   logic [127:0] st_q, st_d, rk_q, rk_d, out_q, out_d;
   logic         rdy_q, rdy_d;
   logic [127:0] rk_next, sr_w, mc_w;
   logic [7:0]   rcon;

   assign rcon = (state_q == ROUNDS) ? RCON[round_q] : 8'h00;

   aes_key_step u_key_step (
      .rk_prev (rk_q),
      .rcon    (rcon),
      .rk_next (rk_next)
   );

   // Byte i = 4*col + row; ShiftRows pulls row r from column (col + r) mod 4.
   for (genvar i = 0; i < 16; i++) begin : g_byte
      localparam int C = i / 4;
      localparam int R = i % 4;
      localparam int SRC = 4 * ((C + R) % 4) + R;
      localparam int B1 = 4 * C + (R + 1) % 4;
      localparam int B2 = 4 * C + (R + 2) % 4;
      localparam int B3 = 4 * C + (R + 3) % 4;
      assign sr_w[127-8*i -: 8] = sbox(st_q[127-8*SRC -: 8]);
      assign mc_w[127-8*i -: 8] = xtime(sr_w[127-8*i -: 8]) ^ xtime(sr_w[127-8*B1 -: 8])
                                  ^ sr_w[127-8*B1 -: 8] ^ sr_w[127-8*B2 -: 8] ^ sr_w[127-8*B3 -: 8];
   end

   always_comb begin
      state_d = state_q;
      round_d = round_q;
      st_d    = st_q;
      rk_d    = rk_q;
      out_d   = out_q;
      rdy_d   = 1'b0;
      if (state_q == IDLE) begin
         if (encryptEnable) begin
            st_d    = inputData ^ key;
            rk_d    = key;
            round_d = 4'd1;
            state_d = ROUNDS;
         end
      end else begin
         st_d    = ((round_q == 4'd10) ? sr_w : mc_w) ^ rk_next;
         rk_d    = rk_next;
         round_d = round_q + 4'd1;
         if (round_q == 4'd10) begin
            out_d   = sr_w ^ rk_next;
            rdy_d   = 1'b1;
            state_d = IDLE;
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= IDLE;
         round_q <= 4'd0;
         st_q    <= 128'h0;
         rk_q    <= 128'h0;
         out_q   <= 128'h0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         round_q <= round_d;
         st_q    <= st_d;
         rk_q    <= rk_d;
         out_q   <= out_d;
         rdy_q   <= rdy_d;
      end
   end

   assign outputData = out_q;
   assign dataReady  = rdy_q;
   assign busy       = (state_q == ROUNDS);

endmodule

// File: tb/tb_aes128_encrypt_core.sv
// tb_aes128_encrypt_core: randomized and FIPS-197 vector checks against a
// byte-matrix AES model whose S-box is derived from GF(2^8) inversion.
module tb_aes128_encrypt_core;

   logic         clk = 1'b0;
   logic         n_rst = 1'b0;
   logic         encryptEnable = 1'b0;
   logic [127:0] key = '0;
   logic [127:0] inputData = '0;
   logic [127:0] outputData;
   logic         dataReady;
   logic         busy;

   int checks = 0;
   int passed = 0;

   logic [7:0] sbox_t [256];
   logic [7:0] isbox_t [256];

   localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   aes128_encrypt_core dut (
      .clk           (clk),
      .n_rst         (n_rst),
      .encryptEnable (encryptEnable),
      .key           (key),
      .inputData     (inputData),
      .outputData    (outputData),
      .dataReady     (dataReady),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   task automatic build_sbox();
      logic [7:0] inv, s;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
         sbox_t[x] = s;
         isbox_t[s] = 8'(x);
      end
   endtask

   function automatic logic [127:0] round_key(input logic [127:0] k, input int n);
      logic [31:0] w [4];
      logic [31:0] t;
      logic [7:0]  rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int j = 1; j <= n; j++) begin
         t = {sbox_t[w[3][23:16]], sbox_t[w[3][15:8]], sbox_t[w[3][7:0]], sbox_t[w[3][31:24]]} ^ {rc, 24'h0};
         w[0] ^= t;
         for (int i = 1; i < 4; i++) w[i] ^= w[i-1];
         rc = gmul(rc, 8'h02);
      end
      return {w[0], w[1], w[2], w[3]};
   endfunction

   function automatic logic [127:0] model_enc(input logic [127:0] k, input logic [127:0] pt);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   ce [4] = '{8'h02, 8'h03, 8'h01, 8'h01};
      logic [127:0] v = pt ^ k;
      for (int rnd = 1; rnd <= 10; rnd++) begin
         for (int i = 0; i < 16; i++) s[i] = sbox_t[v[127-8*i -: 8]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
               s[4*c+r] = 8'h00;
               for (int j = 0; j < 4; j++) s[4*c+r] ^= (rnd == 10) ? ((j == r) ? t[4*c+j] : 8'h00) : gmul(ce[(j-r+4)%4], t[4*c+j]);
            end
         for (int i = 0; i < 16; i++) v[127-8*i -: 8] = s[i];
         v ^= round_key(k, rnd);
      end
      return v;
   endfunction

   function automatic logic [127:0] model_dec(input logic [127:0] k, input logic [127:0] ct);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   ce [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
      logic [127:0] v = ct ^ round_key(k, 10);
      for (int rnd = 9; rnd >= 0; rnd--) begin
         for (int i = 0; i < 16; i++) s[i] = v[127-8*i -: 8];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[4*((c+r)%4)+r] = isbox_t[s[4*c+r]];
         for (int i = 0; i < 16; i++) v[127-8*i -: 8] = t[i];
         v ^= round_key(k, rnd);
         if (rnd > 0) begin
            for (int i = 0; i < 16; i++) t[i] = v[127-8*i -: 8];
            for (int c = 0; c < 4; c++)
               for (int r = 0; r < 4; r++) begin
                  s[4*c+r] = 8'h00;
                  for (int j = 0; j < 4; j++) s[4*c+r] ^= gmul(ce[(j-r+4)%4], t[4*c+j]);
               end
            for (int i = 0; i < 16; i++) v[127-8*i -: 8] = s[i];
         end
      end
      return v;
   endfunction

   // Starts at a falling edge; returns at the falling edge after the completion edge.
   task automatic run_op(input logic [127:0] k, input logic [127:0] d, input bit disturb,
                         output int lat, output int busy_cnt);
      key = k;
      inputData = d;
      encryptEnable = 1'b1;
      @(negedge clk);
      encryptEnable = 1'b0;
      lat = 0;
      busy_cnt = 0;
      while (!dataReady && lat < 30) begin
         if (busy) busy_cnt++;
         if (disturb) begin
            encryptEnable = 1'($urandom_range(0, 1));
            key = '0;
            inputData = '0;
         end
         @(negedge clk);
         lat++;
      end
      encryptEnable = 1'b0;
   endtask

   task automatic test_reset();
      int lat;
      key = {$urandom, $urandom, $urandom, $urandom};
      inputData = {$urandom, $urandom, $urandom, $urandom};
      encryptEnable = 1'b1;
      n_rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (outputData !== 128'h0) $display("FAIL reset_out got %h want 0", outputData); else passed++;
      checks++; if (dataReady !== 1'b0) $display("FAIL reset_ready got %b want 0", dataReady); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
      encryptEnable = 1'b0;
      n_rst = 1'b1;
      @(negedge clk);
      lat = 0;
   endtask

   task automatic test_fips_b();
      int lat, bc;
      run_op(KEY_B, PT_B, 1'b0, lat, bc);
      checks++; if (lat !== 10) $display("FAIL b_latency got %0d want 10", lat); else passed++;
      checks++; if (bc !== 10) $display("FAIL b_busy_cycles got %0d want 10", bc); else passed++;
      checks++; if (outputData !== CT_B) $display("FAIL b_cipher got %h want %h", outputData, CT_B); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL b_busy_done got %b want 0", busy); else passed++;
      @(negedge clk);
      checks++; if (dataReady !== 1'b0) $display("FAIL b_ready_pulse got %b want 0", dataReady); else passed++;
      checks++; if (outputData !== CT_B) $display("FAIL b_hold got %h want %h", outputData, CT_B); else passed++;
   endtask

   task automatic test_fips_c();
      int lat, bc;
      run_op(KEY_C, PT_C, 1'b0, lat, bc);
      checks++; if (lat !== 10) $display("FAIL c_latency got %0d want 10", lat); else passed++;
      checks++; if (outputData !== CT_C) $display("FAIL c_cipher got %h want %h", outputData, CT_C); else passed++;
      @(negedge clk);
   endtask

   task automatic test_busy_immunity();
      int lat, bc;
      run_op(KEY_B, PT_B, 1'b1, lat, bc);
      checks++; if (lat !== 10) $display("FAIL imm_latency got %0d want 10", lat); else passed++;
      checks++; if (outputData !== CT_B) $display("FAIL imm_cipher got %h want %h", outputData, CT_B); else passed++;
      @(negedge clk);
      checks++; if (busy !== 1'b0) $display("FAIL imm_no_restart got %b want 0", busy); else passed++;
   endtask

   task automatic test_random();
      int lat, bc;
      logic [127:0] k, d, exp;
      for (int n = 0; n < 6; n++) begin
         k = {$urandom, $urandom, $urandom, $urandom};
         d = {$urandom, $urandom, $urandom, $urandom};
         exp = model_enc(k, d);
         run_op(k, d, 1'b0, lat, bc);
         checks++; if (outputData !== exp) $display("FAIL rand_cipher[%0d] got %h want %h", n, outputData, exp); else passed++;
         repeat ($urandom_range(1, 3)) @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      int gap;
      key = KEY_C;
      inputData = PT_C;
      encryptEnable = 1'b1;
      gap = 0;
      while (!dataReady && gap < 30) begin @(negedge clk); gap++; end
      checks++; if (outputData !== CT_C) $display("FAIL b2b_first got %h want %h", outputData, CT_C); else passed++;
      key = KEY_B;
      inputData = PT_B;
      gap = 0;
      do begin @(negedge clk); gap++; end while (!dataReady && gap < 30);
      encryptEnable = 1'b0;
      checks++; if (gap !== 11) $display("FAIL b2b_gap got %0d want 11", gap); else passed++;
      checks++; if (outputData !== CT_B) $display("FAIL b2b_second got %h want %h", outputData, CT_B); else passed++;
      @(negedge clk);
      checks++; if (busy !== 1'b0) $display("FAIL b2b_idle got %b want 0", busy); else passed++;
   endtask

   task automatic test_midop_reset();
      int lat, bc, seen;
      key = KEY_C;
      inputData = PT_C;
      encryptEnable = 1'b1;
      @(negedge clk);
      encryptEnable = 1'b0;
      repeat (4) @(negedge clk);
      n_rst = 1'b0;
      #1;
      checks++; if (outputData !== 128'h0) $display("FAIL mid_out got %h want 0", outputData); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL mid_busy got %b want 0", busy); else passed++;
      @(negedge clk);
      n_rst = 1'b1;
      seen = 0;
      repeat (15) begin @(negedge clk); if (dataReady) seen++; end
      checks++; if (seen !== 0) $display("FAIL mid_no_ready got %0d pulses want 0", seen); else passed++;
      run_op(KEY_B, PT_B, 1'b0, lat, bc);
      checks++; if (model_dec(KEY_B, outputData) !== PT_B)
         $display("FAIL roundtrip got %h want %h", model_dec(KEY_B, outputData), PT_B); else passed++;
      @(negedge clk);
   endtask

   initial begin
      build_sbox();
      test_reset();
      test_fips_b();
      test_fips_c();
      test_busy_immunity();
      test_random();
      test_back_to_back();
      test_midop_reset();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/aes128_encrypt_core.md
# aes128_encrypt_core

Iterative AES-128 encryption engine, the forward-direction counterpart of `decryption_block`. It accepts a 128-bit plaintext and key and computes one cipher round per clock with on-the-fly key expansion. It presents the ciphertext with a one-cycle completion pulse. It sits beside `decryption_block` in the AES datapath and produces ciphertext that block consumes.

## Interface
Parameters:
- none. AES-128 only: 10 rounds, 128-bit key.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `n_rst`  in  1  asynchronous, active-low reset.
- `encryptEnable`  in  1  start request; sampled only in IDLE.
- `key`  in  128  cipher key; sampled on the accepting edge only.
- `inputData`  in  128  plaintext; sampled on the accepting edge only.
- `outputData`  out  128  ciphertext; holds its value until the next completion.
- `dataReady`  out  1  one-cycle pulse; high in the cycle after `outputData` updates.
- `busy`  out  1  high while rounds are in progress.

## Operation
- Byte order follows FIPS-197. Byte 0 is `[127:120]`. The state is column-major: bytes 0–3 form column 0.
- FSM states: IDLE and ROUNDS.
  - IDLE → ROUNDS on an edge where `encryptEnable`=1. That edge is the accepting edge.
  - ROUNDS → IDLE on the edge that completes round 10.
- Accepting edge:
  - stateReg ← `inputData` ^ `key` (initial AddRoundKey).
  - rkReg ← `key`.
  - round ← 1, `busy` ← 1.
- Each ROUNDS edge, for r = round:
  - rk_r = expand(rkReg, rcon[r]), computed combinationally.
  - stateReg ← AddRoundKey(MixColumns(ShiftRows(SubBytes(stateReg))), rk_r). Round 10 omits MixColumns.
  - rkReg ← rk_r, round ← r+1.
- Key expansion step: w4 = w0 ^ SubWord(RotWord(w3)) ^ {rcon,24'h0}; w5 = w1 ^ w4; w6 = w2 ^ w5; w7 = w3 ^ w6.
  - rcon sequence for r = 1..10: 01 02 04 08 10 20 40 80 1B 36.
- Round-10 edge:
  - `outputData` ← final state.
  - `dataReady` ← 1 for exactly one cycle.
  - `busy` ← 0; FSM → IDLE.
- `encryptEnable` is ignored while in ROUNDS. Changes to `key` or `inputData` during ROUNDS have no effect.
- Enable held high continuously starts a new operation on the first IDLE edge. Back-to-back throughput is one block per 11 cycles.
- MixColumns uses xtime (shift left, conditional ^ 8'h1B). All arithmetic is GF(2^8) on 8-bit lanes; there are no carries.

## Timing
- Reset values: `outputData`=128'h0, `dataReady`=0, `busy`=0, FSM=IDLE. Internal stateReg, rkReg and round are also cleared.
- Cycle numbering: accepting edge = E0.
  - `busy` is high from E0 through the cycle before E10.
  - `outputData` is valid after E10.
  - `dataReady` is high between E10 and E11.
- Latency: 10 clocks from the accepting edge to ciphertext.
- Next acceptance: at E11 at the earliest.
- Reset asserted mid-operation aborts immediately to reset values, with no partial output. Operation resumes normally after release.
- `outputData` changes only on a round-10 edge or on reset.

## Structure
- Package `aes_pkg`:
  - `sbox` function (256-entry forward S-box).
  - `xtime` function.
  - `RCON` constant array [1:10].
  - FSM state enum `{IDLE, ROUNDS}`.
  - Shared with `decryption_block`, which adds its inverse S-box there.
- Sub-module `aes_key_step`: combinational input (rk_prev[127:0], rcon[7:0]) → rk_next[127:0]. The round datapath (SubBytes, ShiftRows, MixColumns, AddRoundKey) stays in the top module as combinational logic feeding stateReg.

## Test plan
- Reset: assert `n_rst`=0 with random inputs → `outputData`=0, `dataReady`=0, `busy`=0.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, data 3243f6a8885a308d313198a2e0370734, enable pulsed at E0 → at E10 `outputData`=3925841d02dc09fbdc118597196a0b32. `dataReady` is high for exactly one cycle, and `busy` for exactly 10 cycles.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff → 69c4e0d86a7b0430d8cdb78070b4c55a.
- Busy immunity: during ROUNDS of the App. B run, toggle `encryptEnable` and change `key`/`inputData` to 0 → result is still 3925841d…0b32. No second start occurs until IDLE.
- Back-to-back: hold enable high across App. C.1 then App. B inputs, with data changed at E10 → second `dataReady` arrives 11 cycles after the first, with the correct ciphertext.
- Mid-op reset plus round-trip:
  - Assert reset at E5 → outputs zero and no `dataReady`.
  - Then encrypt App. B and feed the ciphertext with the same key into `decryption_block` → plaintext 3243f6a8885a308d313198a2e0370734 is recovered.
